// File: rtl/fwd_pkg.sv
// Shared forwarding types: stage states, select-width helper and the
// core's standard forwarding source indices.
package fwd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        FULL = 2'd2
    } fwd_state_e;

    localparam int FWD_SRC_RF    = 0;
    localparam int FWD_SRC_EXMEM = 1;
    localparam int FWD_SRC_MEMWB = 2;
    localparam int FWD_SRC_MUL   = 3;
    localparam int FWD_NUM_SRC   = 4;

    function automatic int fwd_sel_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fwd_sel_stage_mux_n.sv
// NUM_SRC:1 operand selector; out-of-range selects fall to the last source.
// Also reports the effective (clamped) index it used.
module mux_n
    import fwd_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int NUM_SRC = 4,
    localparam int SEL_W  = fwd_sel_w(NUM_SRC)
) (
    input  logic [SEL_W-1:0]          sel,
    input  logic [NUM_SRC*DATA_W-1:0] din,
    output logic [SEL_W-1:0]          idx,
    output logic [DATA_W-1:0]         dout
);

    localparam logic [SEL_W:0]   NSRC = (SEL_W+1)'(NUM_SRC);
    localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_SRC - 1);

    always_comb begin
        idx  = ({1'b0, sel} < NSRC) ? sel : LAST;
        dout = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (idx == SEL_W'(i)) begin
                dout = din[i*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/fwd_sel_stage.sv
// Operand-forwarding stage: selects one of NUM_SRC sources, waits for it
// to become valid and holds it in an output register behind valid/ready.
module fwd_sel_stage
    import fwd_pkg::*;
#(
    parameter int DATA_W   = 64,
    parameter int NUM_SRC  = 4,
    parameter int WAIT_MAX = 4,
    localparam int SEL_W   = fwd_sel_w(NUM_SRC)
) (
    input  logic                      clk,
    input  logic                      arst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [SEL_W-1:0]          sel,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    input  logic [NUM_SRC-1:0]        src_valid,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_data,
    output logic                      stall,
    output logic                      timeout_err
);

    localparam int CNT_W = $clog2(WAIT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WAIT_MAX);

    fwd_state_e        state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [CNT_W-1:0]  wait_cnt, cnt_d;
    logic [DATA_W-1:0] data_d;
    logic              tmo_d;
    logic [SEL_W-1:0]  mux_sel, idx;
    logic [DATA_W-1:0] mux_data;
    logic              src_ok;
    logic              accept;

    // In WAIT the stored index drives the mux; otherwise the incoming select.
    assign mux_sel = (state_q == WAIT) ? sel_q : sel;

    mux_n #(
        .DATA_W  (DATA_W),
        .NUM_SRC (NUM_SRC)
    ) u_mux (
        .sel  (mux_sel),
        .din  (src_data),
        .idx  (idx),
        .dout (mux_data)
    );

    assign src_ok    = src_valid[idx];
    assign in_ready  = (state_q == IDLE) || (state_q == FULL && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == FULL);
    assign stall     = (state_q == WAIT);

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = wait_cnt;
        data_d  = out_data;
        tmo_d   = timeout_err;
        unique case (state_q)
            IDLE, FULL: begin
                if (state_q == FULL && out_ready) begin
                    state_d = IDLE;
                end
                if (accept) begin
                    sel_d = idx;
                    if (src_ok) begin
                        data_d  = mux_data;
                        state_d = FULL;
                    end else begin
                        cnt_d   = '0;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (src_ok) begin
                    data_d  = mux_data;
                    state_d = FULL;
                end else if (wait_cnt != CNT_MAX) begin
                    cnt_d = wait_cnt + 1'b1;
                    if (cnt_d == CNT_MAX) begin
                        tmo_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            wait_cnt    <= '0;
            out_data    <= '0;
            timeout_err <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            wait_cnt    <= cnt_d;
            out_data    <= data_d;
            timeout_err <= tmo_d;
        end
    end

endmodule

// File: tb/tb_fwd_sel_stage.sv
// Directed bench for fwd_sel_stage: a 4-source and a 3-source instance.
module tb_fwd_sel_stage;

    logic clk = 1'b0;
    logic arst;
    always #5 clk = ~clk;

    logic         in_valid, in_ready, out_valid, out_ready, stall, tmo;
    logic [1:0]   sel;
    logic [255:0] src_data;
    logic [3:0]   src_valid;
    logic [63:0]  out_data;

    logic         in_valid3, in_ready3, out_valid3, out_ready3;
    logic         stall3, tmo3;
    logic [1:0]   sel3;
    logic [191:0] src_data3;
    logic [2:0]   src_valid3;
    logic [63:0]  out_data3;

    int n_run  = 0;
    int n_fail = 0;

    fwd_sel_stage #(.DATA_W(64), .NUM_SRC(4), .WAIT_MAX(4)) dut (
        .clk         (clk),
        .arst        (arst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .sel         (sel),
        .src_data    (src_data),
        .src_valid   (src_valid),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .stall       (stall),
        .timeout_err (tmo)
    );

    fwd_sel_stage #(.DATA_W(64), .NUM_SRC(3), .WAIT_MAX(4)) dut3 (
        .clk         (clk),
        .arst        (arst),
        .in_valid    (in_valid3),
        .in_ready    (in_ready3),
        .sel         (sel3),
        .src_data    (src_data3),
        .src_valid   (src_valid3),
        .out_valid   (out_valid3),
        .out_ready   (out_ready3),
        .out_data    (out_data3),
        .stall       (stall3),
        .timeout_err (tmo3)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int i, input logic [63:0] v);
        src_data[i*64 +: 64] = v;
    endtask

    initial begin
        arst       = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        sel        = '0;
        src_data   = '0;
        src_valid  = '0;
        in_valid3  = 1'b0;
        out_ready3 = 1'b1;
        sel3       = '0;
        src_data3  = '0;
        src_valid3 = '0;
        #3;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_stall", {63'd0, stall}, 64'd0);
        chk("rst_tmo", {63'd0, tmo}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out_data", out_data, 64'd0);
        step();
        step();
        arst = 1'b0;

        // simple hit on source 1
        sel = 2'd1;
        set_src(1, 64'hA5);
        src_valid = 4'b1111;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("hit_valid", {63'd0, out_valid}, 64'd1);
        chk("hit_data", out_data, 64'hA5);
        chk("hit_stall", {63'd0, stall}, 64'd0);
        step();
        chk("hit_drain", {63'd0, out_valid}, 64'd0);

        // source 3 arrives after two wait cycles
        sel = 2'd3;
        src_valid = 4'b0111;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("w2_stall0", {63'd0, stall}, 64'd1);
        chk("w2_in_ready", {63'd0, in_ready}, 64'd0);
        step();
        chk("w2_stall1", {63'd0, stall}, 64'd1);
        set_src(3, 64'h1234);
        src_valid = 4'b1111;
        step();
        chk("w2_valid", {63'd0, out_valid}, 64'd1);
        chk("w2_data", out_data, 64'h1234);
        chk("w2_stall2", {63'd0, stall}, 64'd0);
        chk("w2_tmo", {63'd0, tmo}, 64'd0);
        step();

        // timeout on source 2, then late arrival
        sel = 2'd2;
        src_valid = 4'b1011;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("to_tmo_start", {63'd0, tmo}, 64'd0);
        for (int i = 1; i <= 6; i++) begin
            step();
            chk($sformatf("to_tmo_%0d", i), {63'd0, tmo},
                (i >= 4) ? 64'd1 : 64'd0);
            chk($sformatf("to_stall_%0d", i), {63'd0, stall}, 64'd1);
        end
        set_src(2, 64'hBEEF);
        src_valid = 4'b1111;
        out_ready = 1'b0;
        step();
        chk("to_valid", {63'd0, out_valid}, 64'd1);
        chk("to_data", out_data, 64'hBEEF);
        chk("to_sticky", {63'd0, tmo}, 64'd1);

        // backpressure holds data, then back-to-back handoff
        for (int i = 0; i < 3; i++) begin
            set_src(2, 64'h1000 + 64'(i));
            set_src(0, 64'h2000 + 64'(i));
            step();
            chk($sformatf("bp_data_%0d", i), out_data, 64'hBEEF);
            chk($sformatf("bp_in_ready_%0d", i), {63'd0, in_ready}, 64'd0);
        end
        out_ready = 1'b1;
        in_valid = 1'b1;
        sel = 2'd0;
        set_src(0, 64'd7);
        #1;
        chk("b2b_in_ready", {63'd0, in_ready}, 64'd1);
        step();
        in_valid = 1'b0;
        chk("b2b_valid", {63'd0, out_valid}, 64'd1);
        chk("b2b_data", out_data, 64'd7);
        step();

        // 3-source build: out-of-range select takes source 2
        src_data3[0 +: 64]   = 64'h1;
        src_data3[64 +: 64]  = 64'h2;
        src_data3[128 +: 64] = 64'hC0FFEE;
        src_valid3 = 3'b111;
        sel3 = 2'b11;
        in_valid3 = 1'b1;
        step();
        chk("n3_oor", out_data3, 64'hC0FFEE);
        sel3 = 2'b01;
        step();
        in_valid3 = 1'b0;
        chk("n3_sel1", out_data3, 64'h2);

        // reset in the middle of WAIT
        sel = 2'd2;
        src_valid = 4'b1011;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("ar_tmo_pre", {63'd0, tmo}, 64'd1);
        #2;
        arst = 1'b1;
        #1;
        chk("ar_out_valid", {63'd0, out_valid}, 64'd0);
        chk("ar_stall", {63'd0, stall}, 64'd0);
        chk("ar_tmo", {63'd0, tmo}, 64'd0);
        chk("ar_in_ready", {63'd0, in_ready}, 64'd1);
        chk("ar_data", out_data, 64'd0);
        step();
        arst = 1'b0;
        sel = 2'd1;
        set_src(1, 64'h55);
        src_valid = 4'b1111;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("ar_post_valid", {63'd0, out_valid}, 64'd1);
        chk("ar_post_data", out_data, 64'h55);
        chk("ar_post_tmo", {63'd0, tmo}, 64'd0);
        step();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/fwd_sel_stage.md
Name: fwd_sel_stage

Overview:
- Parametrised N-source operand-forwarding stage for the pipelined core; successor to the fixed 3-input forwarding select.
- Selects one of NUM_SRC candidate operands (register file, EX/MEM, MEM/WB, multi-cycle multiplier result, ...) and registers it behind a valid/ready handshake.
- Stalls the issuing stage while the selected source is not yet valid, e.g. while a multiplier result is still in flight.
- Sits between the ID/EX forwarding logic and the ALU operand register; one instance per operand.

Parameters:
- DATA_W, 64, operand width in bits
- NUM_SRC, 4, number of candidate sources; minimum 2
- SEL_W, $clog2(NUM_SRC), select width; derived, not overridden
- WAIT_MAX, 4, WAIT cycles after which timeout_err is raised; minimum 1

Ports:
- clk  input  1  clock; all state changes on the rising edge
- arst  input  1  asynchronous reset, active-high
- in_valid  input  1  forwarding request present
- in_ready  output  1  stage can accept a request this cycle
- sel  input  SEL_W  source index; sampled on accept
- src_data  input  NUM_SRC*DATA_W  packed sources; source i occupies bits [i*DATA_W +: DATA_W]
- src_valid  input  NUM_SRC  per-source data-valid
- out_valid  output  1  out_data holds a selected operand
- out_ready  input  1  consumer accepts out_data
- out_data  output  DATA_W  registered selected operand
- stall  output  1  high while waiting for the selected source
- timeout_err  output  1  sticky; the WAIT limit was reached

Behaviour:
- Reset (arst high, asynchronous): state=IDLE, sel_q=0, wait_cnt=0, out_data=0, out_valid=0, stall=0, timeout_err=0. in_ready=1 because it decodes from IDLE.
- Effective index = sel when sel < NUM_SRC, otherwise NUM_SRC-1 (out-of-range falls to the last source). The index is stored in sel_q at accept.
- Accept = in_valid && in_ready.
- in_ready = (state==IDLE) || (state==FULL && out_ready). It is low in WAIT.
- States:
  - IDLE. On accept: if src_valid[idx], capture src_data[idx] into out_data and go to FULL. Otherwise go to WAIT with wait_cnt=0.
  - WAIT. stall=1, out_valid=0. Each cycle, if src_valid[sel_q], capture the data and go to FULL. Otherwise increment wait_cnt, saturating at WAIT_MAX. When wait_cnt reaches WAIT_MAX, set timeout_err. The stage keeps waiting; timeout_err does not abort the request.
  - FULL. out_valid=1 and out_data is held stable.
    - out_ready && !in_valid: go to IDLE.
    - out_ready && accept: back-to-back handoff; apply the IDLE accept rules in the same cycle. If the new source is valid, stay FULL with out_valid=1 and new data. If not, go to WAIT.
    - !out_ready: hold the state; src_data changes are ignored.
- Latency: 1 cycle from accept to out_valid when the selected source is valid. When it is not, 1 cycle after src_valid[sel_q] rises.
- Sampling: src_valid/src_data are sampled only at accept (IDLE/FULL) or in WAIT. Data is never captured from a source with src_valid=0.
- stall is a registered state decode: high exactly in the cycles where state==WAIT.
- timeout_err is cleared only by arst.
- arst mid-WAIT or mid-FULL aborts the in-flight operand; all outputs return to reset values asynchronously.

Decomposition:
- Shared package fwd_pkg:
  - state enum {IDLE, WAIT, FULL} (2 bits)
  - sel-width helper function
  - constant FWD_SRC_RF=0 and the standard source index assignments for the core
- Sub-module mux_n: combinational NUM_SRC:1 selector with DATA_W and NUM_SRC parameters and the last-source default for out-of-range selects. It is reused by the forwarding unit and by this stage; the stage itself holds only the FSM, the counter and the output register.

Test Plan:
- Reset, then sel=1 with src_valid=4'b1111 and src1=64'hA5, in_valid=1 for one cycle -> out_valid=1 next cycle, out_data=64'hA5, stall=0 throughout.
- sel=3 with src_valid[3]=0 for 2 cycles, then src3=64'h1234 with src_valid[3]=1 -> stall=1 for 2 cycles, then out_valid=1 with out_data=64'h1234, timeout_err=0.
- sel=2 with src_valid[2] held at 0 for 6 cycles -> timeout_err rises after the 4th WAIT cycle and stays high; stall stays 1. Raise src_valid[2] -> data captured, timeout_err still 1.
- FULL with out_ready=0 for 3 cycles while src_data changes -> out_data stable and in_ready=0. Then out_ready=1 with in_valid=1, sel=0, src0=7 -> out_data=7 next cycle with no out_valid gap.
- NUM_SRC=3 build (SEL_W=2), sel=2'b11 -> out_data equals src2 (last-source default).
- Assert arst mid-WAIT -> out_valid, stall and timeout_err go to 0 immediately and in_ready=1; the next request behaves as after power-up.
